multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle CPU. Decodes the IR opcode and sequences the datapath through fetch, decode, execute, memory and writeback. Drives every datapath select and write enable, including ALUSrcA and ALUSrcB for the ALU operand muxes, and the PCSource/IorD/MemtoReg/RegDst selects. Inserts memory wait states from a ready handshake.

Parameters:
MEM_WAIT_MAX, 8'd15, consecutive MemReady-low cycles in one memory state before MemTimeout sets; 0 disables the timeout counter.

Ports:
Clk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
Op  input  6  opcode, IR[31:26]; stable because IR is written only in FETCH
MemReady  input  1  memory completes the current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU Zero
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  IR load
MemtoReg  output  1  register write data select: 0=ALUOut, 1=MDR
RegDst  output  1  destination register select: 0=rt, 1=rd
RegWrite  output  1  register file write
ALUSrcA  output  1  ALU operand A select: 0=PC, 1=A reg
ALUSrcB  output  2  ALU operand B select: 0=B reg, 1=const 1, 2=sign-ext imm, 3=zero-ext imm
ALUOp  output  2  00=add, 01=sub, 10=funct decode, 11=opcode decode (logical immediate)
PCSource  output  2  PC source: 0=ALU result, 1=ALUOut, 2=jump target
MemTimeout  output  1  sticky; a memory wait exceeded MEM_WAIT_MAX
State  output  4  current state, for debug

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low. Reset forces State=IDLE(0), clears the wait counter and clears MemTimeout. All outputs are 0 in IDLE.
- Output decode: outputs are decoded combinationally from State. FETCH is the only state with Mealy outputs; they depend on MemReady.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000, ANDI=001100, ORI=001101.
- States, with outputs listed; any output not named is 0:
  - IDLE(0): -> FETCH unconditionally.
  - FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=00, PCSource=0. IRWrite=MemReady and PCWrite=MemReady. Holds in FETCH while MemReady=0; -> DECODE when MemReady=1.
  - DECODE(2): ALUSrcA=0, ALUSrcB=2, ALUOp=00, which precomputes the branch target into ALUOut. Next state by opcode: LW/SW->MEMADR, R->RTYPE_EX, BEQ->BRANCH, J->JUMP, ADDI/ANDI/ORI->IMM_EX. Any other opcode -> FETCH, i.e. treated as a NOP.
  - MEMADR(3): ALUSrcA=1, ALUSrcB=2, ALUOp=00. -> MEMRD for LW, -> MEMWR for SW.
  - MEMRD(4): MemRead=1, IorD=1. Holds until MemReady=1, then -> MEMWB.
  - MEMWB(5): RegWrite=1, MemtoReg=1, RegDst=0. -> FETCH.
  - MEMWR(6): MemWrite=1, IorD=1. MemWrite is held until MemReady=1, then -> FETCH.
  - RTYPE_EX(7): ALUSrcA=1, ALUSrcB=0, ALUOp=10. -> RTYPE_WB.
  - RTYPE_WB(8): RegWrite=1, RegDst=1, MemtoReg=0. -> FETCH.
  - BRANCH(9): ALUSrcA=1, ALUSrcB=0, ALUOp=01, PCWriteCond=1, PCSource=1. -> FETCH.
  - JUMP(10): PCWrite=1, PCSource=2. -> FETCH.
  - IMM_EX(11): ALUSrcA=1. ADDI: ALUSrcB=2, ALUOp=00. ANDI/ORI: ALUSrcB=3, ALUOp=11. -> IMM_WB.
  - IMM_WB(12): RegWrite=1, RegDst=0, MemtoReg=0. -> FETCH.
- Latencies with MemReady held at 1: R-type=4 cycles, LW=5, SW=4, BEQ=3, J=3, immediate ops=4.
- Wait counter:
  - Increments each cycle spent in FETCH/MEMRD/MEMWR with MemReady=0.
  - Clears on any state change.
  - Saturates at 8'hFF.
  - When the count equals MEM_WAIT_MAX (and MEM_WAIT_MAX is nonzero), MemTimeout sets on the next edge and stays set until reset. The FSM keeps waiting.
- Reset mid-instruction: returns to IDLE at once. No partial writes follow, because all enables are 0 in IDLE.
- Unused state encodings (13-15) -> IDLE.

Optional Feature:
ILLEGAL_OP_TRAP_EN
- Defined: an undecoded opcode in DECODE goes to TRAP(13). TRAP holds all outputs at 0 and adds output IllegalOp=1. The FSM stays in TRAP until Reset_n is asserted.
- Undefined: undecoded opcodes return to FETCH. There is no TRAP state and no IllegalOp port.

Test Plan:
- Reset, then LW with MemReady=1 throughout -> State sequence 0,1,2,3,4,5,1. ALUSrcB is 1,2,2 in FETCH/DECODE/MEMADR. RegWrite=1 with MemtoReg=1 only in state 5.
- ADDI then ORI -> IMM_EX shows ALUSrcB=2/ALUOp=00 for ADDI and ALUSrcB=3/ALUOp=11 for ORI. Both finish in 4 cycles.
- BEQ -> BRANCH state has ALUSrcA=1, ALUSrcB=0, ALUOp=01, PCWriteCond=1, PCSource=1. J -> JUMP has PCWrite=1, PCSource=2.
- SW with MemReady low for 3 cycles in MEMWR -> MemWrite held for 4 cycles, then FETCH. FETCH with MemReady=0 -> PCWrite=IRWrite=0 until ready.
- MEM_WAIT_MAX=2, MemReady held low in MEMRD -> MemTimeout rises after the 3rd wait cycle and stays 1 after the access completes. Asserting Reset_n low clears it asynchronously.
- Op=111111 -> with the macro: TRAP, IllegalOp=1, outputs held at 0. Without it: DECODE -> FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle CPU.
// Sequences fetch/decode/execute/memory/writeback and drives every datapath
// select and write enable. Memory states stall on MemReady; a wait counter
// raises a sticky MemTimeout after MEM_WAIT_MAX consecutive stalled cycles.
// Build option: define ILLEGAL_OP_TRAP_EN to send undecoded opcodes to a TRAP
// state and expose an IllegalOp output. Without it, such opcodes act as a NOP.
module multicycle_ctrl #(
  parameter logic [7:0] MEM_WAIT_MAX = 8'd15
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       MemTimeout,
  output logic [3:0] State
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic       IllegalOp
`endif
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;

  // ALU operand B encodings
  localparam logic [1:0] SrcBReg   = 2'd0;
  localparam logic [1:0] SrcBOne   = 2'd1;
  localparam logic [1:0] SrcBSext  = 2'd2;
  localparam logic [1:0] SrcBZext  = 2'd3;

  // ALU operation encodings
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;
  localparam logic [1:0] AluOpc   = 2'b11;

  // PC source encodings
  localparam logic [1:0] PcAlu    = 2'd0;
  localparam logic [1:0] PcAluOut = 2'd1;
  localparam logic [1:0] PcJump   = 2'd2;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StRtypeEx = 4'd7,
    StRtypeWb = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StImmEx   = 4'd11,
    StImmWb   = 4'd12
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    StTrap    = 4'd13
`endif
  } state_e;

  state_e     stateQ, stateD;
  logic [7:0] waitCntQ, waitCntD;
  logic       timeoutQ, timeoutD;
  logic       inWait;

  // Opcode class decode; IR only changes in FETCH so these are stable afterwards.
  logic isLw, isSw, isRtype, isBeq, isJ, isAddi, isLogicImm;
  assign isLw       = (Op == OpLw);
  assign isSw       = (Op == OpSw);
  assign isRtype    = (Op == OpRtype);
  assign isBeq      = (Op == OpBeq);
  assign isJ        = (Op == OpJ);
  assign isAddi     = (Op == OpAddi);
  assign isLogicImm = (Op == OpAndi) || (Op == OpOri);

  // State register, wait counter and sticky timeout flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stateQ   <= StIdle;
      waitCntQ <= 8'd0;
      timeoutQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      waitCntQ <= waitCntD;
      timeoutQ <= timeoutD;
    end
  end

  // Next-state sequencing.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle:   stateD = StFetch;
      StFetch:  stateD = MemReady ? StDecode : StFetch;
      StDecode: begin
        if (isLw || isSw) begin
          stateD = StMemAdr;
        end else if (isRtype) begin
          stateD = StRtypeEx;
        end else if (isBeq) begin
          stateD = StBranch;
        end else if (isJ) begin
          stateD = StJump;
        end else if (isAddi || isLogicImm) begin
          stateD = StImmEx;
        end else begin
`ifdef ILLEGAL_OP_TRAP_EN
          stateD = StTrap;
`else
          stateD = StFetch;
`endif
        end
      end
      StMemAdr:  stateD = isLw ? StMemRd : StMemWr;
      StMemRd:   stateD = MemReady ? StMemWb : StMemRd;
      StMemWb:   stateD = StFetch;
      StMemWr:   stateD = MemReady ? StFetch : StMemWr;
      StRtypeEx: stateD = StRtypeWb;
      StRtypeWb: stateD = StFetch;
      StBranch:  stateD = StFetch;
      StJump:    stateD = StFetch;
      StImmEx:   stateD = StImmWb;
      StImmWb:   stateD = StFetch;
`ifdef ILLEGAL_OP_TRAP_EN
      StTrap:    stateD = StTrap;
`endif
      default:   stateD = StIdle;
    endcase
  end

  // Wait counter: counts stalled cycles within one memory state, cleared on
  // any transition; the timeout fires on the edge after the count hits the limit.
  always_comb begin
    inWait   = (stateQ == StFetch) || (stateQ == StMemRd) || (stateQ == StMemWr);
    waitCntD = waitCntQ;
    if (stateD != stateQ) begin
      waitCntD = 8'd0;
    end else if (inWait && !MemReady && (MEM_WAIT_MAX != 8'd0) && (waitCntQ != 8'hFF)) begin
      waitCntD = waitCntQ + 8'd1;
    end
    timeoutD = timeoutQ || ((MEM_WAIT_MAX != 8'd0) && (waitCntQ == MEM_WAIT_MAX));
  end

  // Datapath control decode; FETCH is the only state whose outputs see MemReady.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SrcBReg;
    ALUOp       = AluAdd;
    PCSource    = PcAlu;
`ifdef ILLEGAL_OP_TRAP_EN
    IllegalOp   = 1'b0;
`endif
    case (stateQ)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = SrcBOne;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      // Precompute the branch target into ALUOut.
      StDecode: ALUSrcB = SrcBSext;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBSext;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StRtypeEx: begin
        ALUSrcA = 1'b1;
        ALUOp   = AluFunct;
      end
      StRtypeWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = AluSub;
        PCWriteCond = 1'b1;
        PCSource    = PcAluOut;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = PcJump;
      end
      StImmEx: begin
        ALUSrcA = 1'b1;
        if (isAddi) begin
          ALUSrcB = SrcBSext;
        end else begin
          ALUSrcB = SrcBZext;
          ALUOp   = AluOpc;
        end
      end
      StImmWb: RegWrite = 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
      StTrap:  IllegalOp = 1'b1;
`endif
      default: ;
    endcase
  end

  assign MemTimeout = timeoutQ;
  assign State      = stateQ;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: instruction-level reference model expands each
// instruction into its expected per-cycle behaviour; a monitor checks every cycle.
module tb_multicycle_ctrl;

  localparam logic [7:0] MaxWait = 8'd2;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpAndi = 6'b001100;
  localparam logic [5:0] OpOri  = 6'b001101;

  localparam logic [3:0] SIdle = 4'd0, SFetch = 4'd1, SDecode = 4'd2, SMemAdr = 4'd3;
  localparam logic [3:0] SMemRd = 4'd4, SMemWb = 4'd5, SMemWr = 4'd6, SRtypeEx = 4'd7;
  localparam logic [3:0] SRtypeWb = 4'd8, SBranch = 4'd9, SJump = 4'd10, SImmEx = 4'd11;
  localparam logic [3:0] SImmWb = 4'd12, STrap = 4'd13;

`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memtoReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       illegalOp;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic [5:0] op;
    ctrl_t      c;
  } step_t;

  typedef struct packed {
    logic [3:0] st;
    ctrl_t      c;
    logic       timeout;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [5:0] Op = 6'd0;
  logic       MemReady = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, MemTimeout;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;
  logic       illegalSig;

  multicycle_ctrl #(
    .MEM_WAIT_MAX(MaxWait)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Op         (Op),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource),
    .MemTimeout (MemTimeout),
    .State      (State)
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    .IllegalOp  (illegalSig)
`endif
  );

`ifndef ILLEGAL_OP_TRAP_EN
  assign illegalSig = 1'b0;
`endif

  always #5 Clk = ~Clk;

  ctrl_t actCtrl;
  assign actCtrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                    RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegalSig};

  exp_t  expQ[$];
  step_t plan[$];
  int    checks = 0;
  int    failures = 0;
  bit    modelTimeout = 1'b0;
  int    lowRun = 0;
  logic [5:0] legalOps [8] = '{OpR, OpLw, OpSw, OpBeq, OpJ, OpAddi, OpAndi, OpOri};

  function automatic bit isLegal(input logic [5:0] op);
    return op inside {OpR, OpLw, OpSw, OpBeq, OpJ, OpAddi, OpAndi, OpOri};
  endfunction

  // Control values each state must present.
  function automatic ctrl_t ctl(input logic [3:0] st, input logic rdy, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      SFetch:   begin c.memRead = 1; c.aluSrcB = 2'd1; c.irWrite = rdy; c.pcWrite = rdy; end
      SDecode:  c.aluSrcB = 2'd2;
      SMemAdr:  begin c.aluSrcA = 1; c.aluSrcB = 2'd2; end
      SMemRd:   begin c.memRead = 1; c.iorD = 1; end
      SMemWb:   begin c.regWrite = 1; c.memtoReg = 1; end
      SMemWr:   begin c.memWrite = 1; c.iorD = 1; end
      SRtypeEx: begin c.aluSrcA = 1; c.aluOp = 2'b10; end
      SRtypeWb: begin c.regWrite = 1; c.regDst = 1; end
      SBranch:  begin c.aluSrcA = 1; c.aluOp = 2'b01; c.pcWriteCond = 1; c.pcSource = 2'd1; end
      SJump:    begin c.pcWrite = 1; c.pcSource = 2'd2; end
      SImmEx: begin
        c.aluSrcA = 1;
        if (op == OpAddi) c.aluSrcB = 2'd2;
        else begin c.aluSrcB = 2'd3; c.aluOp = 2'b11; end
      end
      SImmWb:   c.regWrite = 1;
      STrap:    c.illegalOp = 1;
      default:  ;
    endcase
    return c;
  endfunction

  function automatic void add(input logic [3:0] st, input logic rdy, input logic [5:0] op);
    plan.push_back('{st: st, rdy: rdy, op: op, c: ctl(st, rdy, op)});
  endfunction

  // One clock cycle: drive inputs, queue what the DUT must show, advance the timeout model.
  task automatic runStep(input step_t s);
    @(posedge Clk);
    #1;
    Op       = s.op;
    MemReady = s.rdy;
    expQ.push_back('{st: s.st, c: s.c, timeout: modelTimeout});
    if (lowRun == int'(MaxWait)) modelTimeout = 1'b1;
    if ((s.st == SFetch || s.st == SMemRd || s.st == SMemWr) && !s.rdy)
      lowRun = (lowRun < 255) ? lowRun + 1 : 255;
    else
      lowRun = 0;
  endtask

  // Async reset asserted mid-cycle: IDLE with all outputs low immediately.
  task automatic doReset(input int hold);
    @(posedge Clk);
    #1;
    Reset_n      = 1'b0;
    MemReady     = 1'($urandom);
    modelTimeout = 1'b0;
    lowRun       = 0;
    expQ.push_back('{st: SIdle, c: '0, timeout: 1'b0});
    repeat (hold) begin
      @(posedge Clk);
      #1;
      expQ.push_back('{st: SIdle, c: '0, timeout: 1'b0});
    end
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    expQ.push_back('{st: SIdle, c: '0, timeout: 1'b0});
  endtask

  // Expand one instruction into cycles; cut>0 truncates it (caller then resets).
  task automatic execInstr(input logic [5:0] op, input int fw, input int mw, input int cut,
                           output bit mustReset);
    int n;
    plan.delete();
    for (int i = 0; i < fw; i++) add(SFetch, 1'b0, op);
    add(SFetch, 1'b1, op);
    add(SDecode, 1'($urandom), op);
    case (op)
      OpLw: begin
        add(SMemAdr, 1'($urandom), op);
        for (int i = 0; i < mw; i++) add(SMemRd, 1'b0, op);
        add(SMemRd, 1'b1, op);
        add(SMemWb, 1'($urandom), op);
      end
      OpSw: begin
        add(SMemAdr, 1'($urandom), op);
        for (int i = 0; i < mw; i++) add(SMemWr, 1'b0, op);
        add(SMemWr, 1'b1, op);
      end
      OpR:   begin add(SRtypeEx, 1'($urandom), op); add(SRtypeWb, 1'($urandom), op); end
      OpBeq: add(SBranch, 1'($urandom), op);
      OpJ:   add(SJump, 1'($urandom), op);
      OpAddi, OpAndi, OpOri: begin
        add(SImmEx, 1'($urandom), op);
        add(SImmWb, 1'($urandom), op);
      end
      default: if (TrapEn) repeat (3) add(STrap, 1'($urandom), op);
    endcase
    mustReset = TrapEn && !isLegal(op);
    n = plan.size();
    if (cut > 0 && cut < n) begin
      n = cut;
      mustReset = 1'b1;
    end
    for (int i = 0; i < n; i++) runStep(plan[i]);
  endtask

  // Monitor: every queued expectation is compared mid-cycle.
  always @(negedge Clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (State !== e.st || actCtrl !== e.c || MemTimeout !== e.timeout) begin
        failures++;
        $display("FAIL cycle t=%0t State act=%0d req=%0d ctrl act=%h req=%h MemTimeout act=%b req=%b",
                 $time, State, e.st, actCtrl, e.c, MemTimeout, e.timeout);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit mr;
    logic [5:0] op;
    int nInstr;
    doReset(1);
    // Directed: each opcode class, stalls, and the timeout boundary.
    execInstr(OpLw,   0, 0, 0, mr);
    execInstr(OpAddi, 0, 0, 0, mr);
    execInstr(OpOri,  0, 0, 0, mr);
    execInstr(OpBeq,  0, 0, 0, mr);
    execInstr(OpJ,    0, 0, 0, mr);
    execInstr(OpSw,   0, 3, 0, mr);
    execInstr(OpR,    1, 0, 0, mr);
    execInstr(OpLw,   0, 4, 0, mr);
    execInstr(OpAndi, 0, 0, 0, mr);
    doReset(0);
    execInstr(6'b111111, 0, 0, 0, mr);
    if (mr) doReset(0);
    execInstr(OpR, 0, 0, 3, mr);
    // Random programs, occasionally cut short by a reset.
    for (int seg = 0; seg < 30; seg++) begin
      doReset($urandom_range(0, 2));
      nInstr = $urandom_range(1, 6);
      for (int k = 0; k < nInstr; k++) begin
        if ($urandom_range(0, 9) < 8) begin
          op = legalOps[$urandom_range(0, 7)];
        end else begin
          op = 6'($urandom);
          if (isLegal(op)) op = 6'b111111;
        end
        execInstr(op, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                  $urandom_range(0, 4),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0, mr);
        if (mr) break;
      end
    end
    doReset(0);
    @(negedge Clk);
    @(negedge Clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain pending act=%0d req=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
